// File: rtl/enc_pkg.sv
// Shared widths and types for the 64-to-6 highest-set-bit encoder.
package enc_pkg;

  localparam int unsigned ENC_IN_W  = 64;
  localparam int unsigned ENC_OUT_W = 6;
  localparam int unsigned ENC_GRP_W = 8;
  localparam int unsigned ENC_GRP_N = 8;

  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

  // Result of one 8-bit group encoder.
  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } grp_res_t;

endpackage : enc_pkg

// File: rtl/enc_8b.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
// The any_o output flags a non-zero input. An all-zero input gives idx_o = 0.
module enc_8b (
  input  logic [7:0] in_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Ascending scan, so a later (higher) set bit overrides a lower one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (in_i[i]) begin
        idx_o = i[2:0];
        any_o = 1'b1;
      end
    end
  end

endmodule : enc_8b

// File: rtl/onehot_enc_64b.sv
// One-hot (nominal) 64-bit word to 6-bit index encoder with a valid strobe.
// A non-one-hot input resolves to its highest set bit, and an all-zero input
// resolves to 0. The data path ignores valid.
// A two-level tree builds the result. Eight byte-group encoders run first,
// then one encoder runs over their "any" flags, and the selected local index
// is muxed in after that.
// OUT_REG = 1 gives a single async-reset output register stage.
// OUT_REG = 0 gives a purely combinational path.
module onehot_enc_64b
  import enc_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic [5:0]  out_data_o,
  output logic        out_valid_o
);

  grp_res_t   grp_res [ENC_GRP_N];
  logic [ENC_GRP_N-1:0] grp_any;
  logic [2:0] grp_sel;
  logic       grp_any_unused;
  enc_idx_t   enc_idx;

  // Level 1: one priority encoder per byte group.
  for (genvar g = 0; g < ENC_GRP_N; g++) begin : g_grp
    enc_8b u_enc_grp (
      .in_i  (in_data_i[g*ENC_GRP_W +: ENC_GRP_W]),
      .idx_o (grp_res[g].idx),
      .any_o (grp_res[g].any)
    );
    assign grp_any[g] = grp_res[g].any;
  end

  // Level 2: the highest non-empty group selects the upper index bits.
  // Its own "any" would only mean "input non-zero", and the design has no
  // zero flag, so that output is left unused.
  enc_8b u_enc_sel (
    .in_i  (grp_any),
    .idx_o (grp_sel),
    .any_o (grp_any_unused)
  );

  // Group index on top, with the selected group's local index below it.
  always_comb begin
    enc_idx = {grp_sel, grp_res[grp_sel].idx};
  end

  if (OUT_REG != 0) begin : g_reg
    enc_idx_t out_data_d, out_data_q;
    logic     out_valid_d, out_valid_q;

    // Next-state is the fresh encode and valid every cycle, with no hold term.
    always_comb begin
      out_data_d  = enc_idx;
      out_valid_d = in_valid_i;
    end

    // Output register. Reset clears it at once and drops any in-flight result.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
  end else begin : g_comb
    logic clk_rst_unused;

    assign clk_rst_unused = clk_i ^ rst_i;
    assign out_data_o     = enc_idx;
    assign out_valid_o    = in_valid_i;
  end

endmodule : onehot_enc_64b

// File: tb/tb_onehot_enc_64b.sv
// Directed plus random checks of onehot_enc_64b in registered and combinational modes.
module tb_onehot_enc_64b;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic [5:0]  r_data, c_data;
  logic        r_valid, c_valid;

  int n_pass  = 0;
  int n_total = 0;

  onehot_enc_64b #(.OUT_REG(1)) dut_reg (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .out_data_o(r_data), .out_valid_o(r_valid)
  );

  onehot_enc_64b #(.OUT_REG(0)) dut_comb (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .out_data_o(c_data), .out_valid_o(c_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // This reference model scans the whole word for its highest set bit.
  function automatic logic [5:0] ref_hsb(input logic [63:0] w);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) if (w[i]) r = 6'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] one;
    one = 64'd1;
    rst = 1'b1; in_valid = 1'b1; in_data = one << 40;
    tick(); tick();
    n_total++;
    if (r_data !== 6'd0 || r_valid !== 1'b0)
      $display("FAIL reset_hold: got data=%0d valid=%0b want data=0 valid=0", r_data, r_valid);
    else n_pass++;
    n_total++;
    if (c_data !== 6'd40 || c_valid !== 1'b1)
      $display("FAIL reset_comb: got data=%0d valid=%0b want data=40 valid=1", c_data, c_valid);
    else n_pass++;
    rst = 1'b0;
    #2;
    n_total++;
    if (r_data !== 6'd0 || r_valid !== 1'b0)
      $display("FAIL reset_release_no_edge: got data=%0d valid=%0b want data=0 valid=0", r_data, r_valid);
    else n_pass++;
    tick();
    n_total++;
    if (r_data !== 6'd40 || r_valid !== 1'b1)
      $display("FAIL reset_first_capture: got data=%0d valid=%0b want data=40 valid=1", r_data, r_valid);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [63:0] one;
    one = 64'd1;
    for (int i = 0; i < 64; i++) begin
      in_data = one << i; in_valid = 1'b1;
      #1;
      n_total++;
      if (c_data !== 6'(i) || c_valid !== 1'b1)
        $display("FAIL comb_sweep[%0d]: got data=%0d valid=%0b want data=%0d valid=1", i, c_data, c_valid, i);
      else n_pass++;
      tick();
      n_total++;
      if (r_data !== 6'(i) || r_valid !== 1'b1)
        $display("FAIL reg_sweep[%0d]: got data=%0d valid=%0b want data=%0d valid=1", i, r_data, r_valid, i);
      else n_pass++;
    end
    in_valid = 1'b0;
    #1;
    n_total++;
    if (r_valid !== 1'b1 || c_valid !== 1'b0)
      $display("FAIL valid_drop_pre_edge: got reg=%0b comb=%0b want reg=1 comb=0", r_valid, c_valid);
    else n_pass++;
    tick();
    n_total++;
    if (r_valid !== 1'b0 || r_data !== 6'd63)
      $display("FAIL valid_drop_post_edge: got valid=%0b data=%0d want valid=0 data=63", r_valid, r_data);
    else n_pass++;
  endtask

  task automatic test_priority();
    logic [63:0] vec [4];
    logic [5:0]  exp [4];
    vec[0] = 64'h8000_0000_0000_0001; exp[0] = 6'd63;
    vec[1] = 64'h0000_0000_0001_0100; exp[1] = 6'd16;
    vec[2] = 64'h0000_0000_0000_0F00; exp[2] = 6'd11;
    vec[3] = 64'h0;                   exp[3] = 6'd0;
    for (int k = 0; k < 4; k++) begin
      in_data = vec[k]; in_valid = 1'b1;
      #1;
      n_total++;
      if (c_data !== exp[k] || c_valid !== 1'b1)
        $display("FAIL comb_priority[%0d]: got data=%0d valid=%0b want data=%0d valid=1", k, c_data, c_valid, exp[k]);
      else n_pass++;
      tick();
      n_total++;
      if (r_data !== exp[k] || r_valid !== 1'b1)
        $display("FAIL reg_priority[%0d]: got data=%0d valid=%0b want data=%0d valid=1", k, r_data, r_valid, exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [63:0] one;
    one = 64'd1;
    in_valid = 1'b1;
    for (int i = 16; i < 24; i++) begin
      in_data = one << i;
      if (i == 20) begin
        #3 rst = 1'b1;
        #1;
        n_total++;
        if (r_data !== 6'd0 || r_valid !== 1'b0)
          $display("FAIL midreset_async: got data=%0d valid=%0b want data=0 valid=0", r_data, r_valid);
        else n_pass++;
        n_total++;
        if (c_data !== 6'd20 || c_valid !== 1'b1)
          $display("FAIL midreset_comb: got data=%0d valid=%0b want data=20 valid=1", c_data, c_valid);
        else n_pass++;
        tick();
        n_total++;
        if (r_data !== 6'd0 || r_valid !== 1'b0)
          $display("FAIL midreset_held: got data=%0d valid=%0b want data=0 valid=0", r_data, r_valid);
        else n_pass++;
        #2 rst = 1'b0;
      end
      tick();
      n_total++;
      if (r_data !== 6'(i) || r_valid !== 1'b1)
        $display("FAIL midreset_resume[%0d]: got data=%0d valid=%0b want data=%0d valid=1", i, r_data, r_valid, i);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [63:0] w;
    logic        v;
    logic [5:0]  e;
    for (int n = 0; n < 10000; n++) begin
      w = {$urandom(), $urandom()};
      case (n % 4)
        0: w = w >> $urandom_range(63, 0);
        1: w = 64'd1 << $urandom_range(63, 0);
        default: ;
      endcase
      v = 1'($urandom_range(1, 0));
      e = ref_hsb(w);
      in_data = w; in_valid = v;
      #1;
      n_total++;
      if (c_data !== e || c_valid !== v)
        $display("FAIL comb_random[%0d]: in=%h got data=%0d valid=%0b want data=%0d valid=%0b", n, w, c_data, c_valid, e, v);
      else n_pass++;
      tick();
      n_total++;
      if (r_data !== e || r_valid !== v)
        $display("FAIL reg_random[%0d]: in=%h got data=%0d valid=%0b want data=%0d valid=%0b", n, w, r_data, r_valid, e, v);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0;
    test_reset();
    test_sweep();
    test_priority();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_onehot_enc_64b

// File: doc/onehot_enc_64b.md
Name: onehot_enc_64b

Overview:
- Encodes a 64-bit one-hot word into its 6-bit bit index, with an accompanying valid strobe.
- Generic utility leaf used wherever a one-hot grant, select or bit-position vector must become a binary index.
- Non-one-hot inputs are resolved deterministically by priority: the highest set bit wins.
- Output stage is optionally registered, selected by a parameter.

Parameters:
- OUT_REG, default 1: 1 = outputs registered, 1-cycle latency; 0 = purely combinational, 0-cycle latency.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_data_i  input  64  one-hot (nominal) input word.
- in_valid_i  input  1  qualifies in_data_i.
- out_data_o  output  6  binary index of the highest set bit of in_data_i.
- out_valid_o  output  1  qualifies out_data_o.

Behaviour:
- Encoding: out_data = max{ i | in_data_i[i] = 1 }.
  - One-hot input 1<<k gives k, for k = 0..63.
  - Multiple bits set: highest index wins, e.g. 0x8000_0000_0000_0001 gives 63.
  - All-zero input gives 0; valid still follows in_valid_i, with no separate zero flag.
- Encoding is computed regardless of in_valid_i. The data path is not gated by valid; consumers qualify with out_valid_o.
- OUT_REG = 1:
  - out_data_o and out_valid_o are registered on the rising clk_i edge, giving exactly 1 cycle of latency.
  - Input sampled at edge N appears after edge N and holds until edge N+1.
  - rst_i asserted: out_data_o = 6'd0 and out_valid_o = 0 immediately (async), held while rst_i = 1.
  - First capture happens on the first rising edge after deassertion.
  - Reset mid-stream drops the in-flight result; no recovery state exists.
- OUT_REG = 0:
  - out_data_o = f(in_data_i) and out_valid_o = in_valid_i, combinationally.
  - clk_i and rst_i are unused; no registers are inferred.
- No handshake or backpressure: every valid input produces exactly one valid output, one per cycle, back-to-back at full throughput.
- Structure: two-level priority tree.
  - Level 1: eight 8-bit priority encoders, one per byte group g = 0..7. Each yields a 3-bit local index and an "any" flag.
  - Level 2: an 8-bit priority encoder over the eight "any" flags yields group index G.
  - out_data = {G, local_index[G]}.
- Combinational path from in_data_i to the register input is at most two 8-bit encoders plus one 8:1 mux of 3 bits.

Decomposition:
- Package enc_pkg:
  - Localparams ENC_IN_W = 64, ENC_OUT_W = 6, ENC_GRP_W = 8, ENC_GRP_N = 8.
  - Typedef enc_idx_t (logic [5:0]).
- One sub-module, enc_8b:
  - Combinational 8-to-3 priority encoder with an "any" output, highest bit wins.
  - Instantiated 9 times: 8 groups plus 1 group selector.
- Top handles the group mux, the OUT_REG generate branch and the async-reset register.

Test Plan:
- Reset:
  - Stimulus: OUT_REG = 1, rst_i = 1 with in_valid_i = 1 and in_data_i = 1<<40.
  - Required: out_valid_o = 0 and out_data_o = 0 while in reset.
  - Deassert rst_i; on the next edge, out_data_o = 40 and out_valid_o = 1.
- One-hot sweep:
  - Stimulus: OUT_REG = 1, in_valid_i = 1, in_data_i = 1<<i for i = 0..63 on consecutive cycles.
  - Required: out_data_o = i one cycle later, out_valid_o = 1 throughout.
  - Drop in_valid_i; out_valid_o falls one cycle later.
- Priority:
  - in_data_i = 0x8000_0000_0000_0001 gives 63.
  - 0x0000_0000_0001_0100 gives 16.
  - 0x0F00 gives 11.
  - All-zero gives 0.
- Combinational mode:
  - Stimulus: OUT_REG = 0, same sweep as the one-hot sweep.
  - Required: out_data_o = i and out_valid_o = in_valid_i in the same cycle; toggling rst_i has no effect.
- Reset mid-stream:
  - Stimulus: assert rst_i asynchronously (between edges) during the sweep at i = 20.
  - Required: outputs go to 0 and 0 within the same cycle, without waiting for a clock edge.
  - After release, results resume with the currently presented index.
- Random:
  - Stimulus: 10k random 64-bit words with random in_valid_i.
  - Required: checked against a reference highest-set-bit model, 1-cycle delayed (OUT_REG = 1).
